// File: rtl/uart_tx_16x_if.sv
// Byte handshake between the upstream host/FIFO and the UART transmitter.
interface uart_tx_16x_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Host side: offers a byte, observes ready
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: captures a byte when valid && ready
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_16x.sv
// UART transmitter for a 16x-oversampling receiver.
// Double buffered: one byte in the shifter on the line plus one byte in the
// holding register, so consecutive frames leave the line with no idle gap.
module uart_tx_16x #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         baud_tick,
    uart_tx_16x_if.slave tx_if,
    output logic         TXD,
    output logic         tx_busy,
    output logic         tx_done
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IDX_W  = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic bit_end;
    logic last_data;
    logic last_stop;
    logic frame_end;
    logic accept;
    logic load;

    // Bit timing and transfer qualifiers shared by next-state and output logic
    assign bit_end   = baud_tick && (tick_cnt_q == TICK_LAST);
    assign last_data = (bit_idx_q == DATA_LAST);
    assign last_stop = (bit_idx_q == STOP_LAST);
    assign frame_end = (state_q == S_STOP) && bit_end && last_stop;
    assign accept    = tx_if.tx_valid && tx_ready_q;
    assign load      = hold_full_q && ((state_q == S_IDLE) || frame_end);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: walk the frame fields, chaining straight into the next frame if one is held
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && last_data) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (frame_end) begin
                    state_d = hold_full_q ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath: holding register, shifter, counters and registered line level
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        done_d      = 1'b0;
        txd_d       = 1'b1;
        busy_d      = 1'b0;
        tx_ready_d  = tx_ready_q;

        if (accept) begin
            hold_d      = tx_if.tx_data;
            hold_full_d = 1'b1;
        end

        // Counters only advance on baud ticks, so the frame freezes while ticks are absent
        if ((state_q != S_IDLE) && baud_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
        end

        // bit_idx counts bits within the current field and restarts on every field change
        if (bit_end) begin
            bit_idx_d = (state_d != state_q) ? '0 : bit_idx_q + IDX_W'(1);
        end

        if ((state_q == S_DATA) && bit_end) begin
            shift_d = shift_q >> 1;
        end

        // Parity is frozen from the loaded byte, independent of whatever is held next
        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_q;
            parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
            tick_cnt_d  = '0;
            bit_idx_d   = '0;
        end

        done_d = frame_end;

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase

        busy_d     = (state_d != S_IDLE);
        tx_ready_d = !hold_full_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ready_q  <= tx_ready_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign TXD            = txd_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;
    assign tx_if.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_16x.sv
// Bench for uart_tx_16x: a driver pushes every accepted byte into a scoreboard
// queue; a tick-counting receiver model rebuilds each frame from TXD and
// compares it against the frame derived from the popped byte.
module tb_uart_tx_16x;

    localparam int unsigned DB          = 8;
    localparam int unsigned OS          = 16;
    localparam int unsigned PEN         = 1;
    localparam int unsigned PODD        = 0;
    localparam int unsigned NSTOP       = 1;
    localparam int unsigned NBITS       = 1 + DB + PEN + NSTOP;
    localparam int unsigned FRAME_TICKS = NBITS * OS;
    localparam int          WAIT_LIMIT  = 20000;

    logic clk;
    logic reset;
    logic baud_tick;
    logic TXD;
    logic tx_busy;
    logic tx_done;

    uart_tx_16x_if #(.DATA_BITS(DB)) tx_if ();

    uart_tx_16x #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .PARITY_EN (PEN),
        .PARITY_ODD(PODD),
        .STOP_BITS (NSTOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_tick(baud_tick),
        .tx_if    (tx_if),
        .TXD      (TXD),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_mode = 0;
    int tick_phase = 0;

    logic [DB-1:0] exp_q[$];

    bit               mon_active    = 1'b0;
    bit               mon_last_tick = 1'b0;
    bit               mon_tick_used;
    int               mon_m;
    logic [NBITS-1:0] mon_obs;
    logic [NBITS-1:0] mon_seen;
    bit               mon_glitch;
    bit               mon_busy_err;
    bit               mon_done_err;
    logic [DB-1:0]    mon_exp;
    bit               idle_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s
    function automatic logic [NBITS-1:0] frame_of(input logic [DB-1:0] d);
        logic [NBITS-1:0] f;
        int unsigned      pos;
        f      = '1;
        f[0]   = 1'b0;
        pos    = 1;
        for (int i = 0; i < int'(DB); i++) begin
            f[pos] = d[i];
            pos    = pos + 1;
        end
        if (PEN != 0) begin
            f[pos] = ((($countones(d) + PODD) % 2) == 1);
        end
        return f;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Baud tick source: 0 = always on, 1 = one in four clocks, 2 = random one in three
    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_phase = (tick_phase + 1) % 4;
            case (tick_mode)
                0:       baud_tick = 1'b1;
                1:       baud_tick = (tick_phase == 0);
                default: baud_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic start_frame();
        check("frame_was_expected", 32'(exp_q.size() != 0), 32'd1);
        mon_exp      = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        mon_active   = 1'b1;
        mon_m        = 0;
        mon_seen     = '0;
        mon_obs      = '1;
        mon_seen[0]  = 1'b1;
        mon_obs[0]   = TXD;
        mon_glitch   = 1'b0;
        mon_busy_err = (tx_busy !== 1'b1);
        mon_done_err = 1'b0;
    endtask

    task automatic finish_frame();
        check("frame_bits", 32'(mon_obs), 32'(frame_of(mon_exp)));
        check("bit_stable_for_full_bit", 32'(mon_glitch), 32'd0);
        check("busy_during_frame", 32'(mon_busy_err), 32'd0);
        check("no_early_done", 32'(mon_done_err), 32'd0);
        check("done_at_stop_end", 32'(tx_done), 32'd1);
        check("busy_after_stop", 32'(tx_busy), 32'(TXD == 1'b0));
    endtask

    // Receiver model: counts baud ticks consumed since the start edge; bit k spans ticks [k*OS, k*OS+OS)
    initial begin
        int k;
        forever begin
            @(negedge clk);
            mon_tick_used = mon_last_tick;
            mon_last_tick = baud_tick;
            if (reset) begin
                mon_active = 1'b0;
                exp_q.delete();
            end else if (mon_active) begin
                if (mon_tick_used) mon_m++;
                if (mon_m < int'(FRAME_TICKS)) begin
                    k = mon_m / int'(OS);
                    if (!mon_seen[k]) begin
                        mon_seen[k] = 1'b1;
                        mon_obs[k]  = TXD;
                    end else if (mon_obs[k] !== TXD) begin
                        mon_glitch = 1'b1;
                    end
                    if (tx_busy !== 1'b1) mon_busy_err = 1'b1;
                    if (tx_done !== 1'b0) mon_done_err = 1'b1;
                end else begin
                    finish_frame();
                    if (TXD === 1'b0) start_frame();
                    else mon_active = 1'b0;
                end
            end else begin
                if (TXD === 1'b0) start_frame();
                else if (tx_busy !== 1'b0 || tx_done !== 1'b0) idle_err = 1'b1;
            end
        end
    end

    // Offer one byte, hold valid through any stall, record the accepting cycle
    task automatic send(input logic [DB-1:0] d, output int acc_cyc);
        int waitc;
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        waitc = 0;
        while (tx_if.tx_ready !== 1'b1 && waitc < WAIT_LIMIT) begin
            @(negedge clk);
            waitc++;
        end
        if (tx_if.tx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: tx_ready still %b after %0d cycles, expected 1", tx_if.tx_ready, waitc);
            tx_if.tx_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            exp_q.push_back(d);
            #1;
            tx_if.tx_valid = 1'b0;
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_idle();
        int waitc;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while ((exp_q.size() != 0 || mon_active || tx_busy !== 1'b0) && waitc < WAIT_LIMIT);
        if (exp_q.size() != 0 || mon_active || tx_busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: pending=%0d active=%b busy=%b, expected all clear", exp_q.size(), mon_active, tx_busy);
        end
    endtask

    initial begin
        int a1;
        int a2;
        int gap;
        logic [DB-1:0] fixed_bytes [3];

        reset          = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        tick_mode      = 0;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(TXD), 32'd1);
        check("reset_ready", 32'(tx_if.tx_ready), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        #2 reset = 1'b0;

        // 0x55 with ticks every clock: line falls on the edge after the accepting edge
        send(8'h55, a1);
        @(negedge clk);
        check("txd_idle_after_accept", 32'(TXD), 32'd1);
        check("ready_low_after_accept", 32'(tx_if.tx_ready), 32'd0);
        @(negedge clk);
        check("txd_start_after_load", 32'(TXD), 32'd0);
        check("ready_high_after_load", 32'(tx_if.tx_ready), 32'd1);
        wait_idle();

        send(8'hA7, a1);
        wait_idle();

        // Back-to-back: second byte accepted one cycle after the first loads
        send(8'h0F, a1);
        send(8'hF0, a2);
        check("b2b_accept_spacing", 32'(a2 - a1), 32'd2);
        @(negedge clk);
        check("ready_low_while_held", 32'(tx_if.tx_ready), 32'd0);
        wait_idle();

        // Sparse ticks stretch bits but do not change their values
        tick_mode = 1;
        send(8'h3C, a1);
        wait_idle();
        tick_mode = 0;

        // Reset in data bit 3 of 0x81 with 0x42 held
        send(8'h81, a1);
        send(8'h42, a2);
        repeat (70) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midframe_reset_txd", 32'(TXD), 32'd1);
        check("midframe_reset_ready", 32'(tx_if.tx_ready), 32'd1);
        check("midframe_reset_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (200) @(negedge clk);
        check("post_reset_line_idle", 32'(TXD), 32'd1);
        check("post_reset_not_busy", 32'(tx_busy), 32'd0);
        check("post_reset_ready", 32'(tx_if.tx_ready), 32'd1);

        // Loopback-style frames through the receiver model
        fixed_bytes[0] = 8'h00;
        fixed_bytes[1] = 8'hFF;
        fixed_bytes[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            send(fixed_bytes[i], a1);
        end
        wait_idle();

        // Randomised bytes, gaps and tick patterns
        for (int i = 0; i < 30; i++) begin
            tick_mode = $urandom_range(0, 2);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            repeat (gap) @(negedge clk);
            send(DB'($urandom), a1);
        end
        wait_idle();

        check("idle_line_clean", 32'(idle_err), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
